// File: rtl/dc_bu_line_write_ctrl.sv
// dc_bu_line_write_ctrl: writes incoming pixel lines into one-hot selected line buffers,
// signals line ends and decides per line (vertical DDA) whether the buffers rotate.
module dc_bu_line_write_ctrl #(
  parameter int BUFFER_NUM = 5,
  parameter int PIX_W      = 24,
  parameter int ADDR_W     = 11,
  parameter int LINE_W     = 1920,
  parameter int FRAC_W     = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [PIX_W-1:0]      pix_data,
  input  logic                  pix_sof,
  input  logic                  pix_eol,
  input  logic [FRAC_W:0]       v_step,
  input  logic [BUFFER_NUM-1:0] write_buff,
  output logic [BUFFER_NUM-1:0] wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [PIX_W-1:0]      wr_data,
  output logic                  next_line,
  output logic                  no_func_switch,
  output logic                  line_ovf
);
  localparam int CNT_W = $clog2(LINE_W + 1);
  localparam logic [FRAC_W:0] ONE = {1'b1, {FRAC_W{1'b0}}};
  typedef enum logic [1:0] {IDLE, ACTIVE, LINE_END} state_t;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      pix_cnt_q, pix_cnt_d;
  logic [FRAC_W-1:0]     acc_q, acc_d;
  logic [FRAC_W:0]       step_q, step_d, sum;
  logic                  ovf_q, ovf_d;
  logic [BUFFER_NUM-1:0] wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]      wr_data_q, wr_data_d;
  logic                  accept, px_acc, room, do_wr, keep;
  assign pix_ready      = nrst & en & (state_q != LINE_END);
  assign accept         = pix_valid & pix_ready;
  assign px_acc         = accept & (pix_sof | (state_q == ACTIVE));
  assign room           = pix_cnt_q < CNT_W'(LINE_W);
  assign do_wr          = px_acc & (pix_sof | room);
  assign sum            = {1'b0, acc_q} + step_q;
  assign keep           = sum[FRAC_W];
  assign next_line      = en & (state_q == LINE_END);
  assign no_func_switch = next_line & ~keep;
  assign wr_en          = en ? wr_en_q : '0;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign line_ovf       = ovf_q;
  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    acc_d     = acc_q;
    step_d    = step_q;
    ovf_d     = ovf_q;
    wr_en_d   = do_wr ? write_buff : '0;
    wr_addr_d = do_wr ? (pix_sof ? '0 : ADDR_W'(pix_cnt_q)) : wr_addr_q;
    wr_data_d = do_wr ? pix_data : wr_data_q;
    if (accept && pix_sof) begin
      state_d   = ACTIVE;
      pix_cnt_d = CNT_W'(1);
      acc_d     = '0;
      step_d    = (v_step > ONE) ? ONE : v_step;
      ovf_d     = 1'b0;
    end else if (px_acc) begin
      pix_cnt_d = room ? pix_cnt_q + CNT_W'(1) : pix_cnt_q;
      ovf_d     = ovf_q | ~room;
    end
    if (px_acc && pix_eol) begin
      state_d   = LINE_END;
      pix_cnt_d = '0;
    end
    // LINE_END never accepts pixels, so it cannot collide with the branches above
    if (state_q == LINE_END && en) begin
      state_d = ACTIVE;
      acc_d   = sum[FRAC_W-1:0];
    end
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      acc_q     <= '0;
      step_q    <= ONE;
      ovf_q     <= 1'b0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (en) begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_dc_bu_line_write_ctrl.sv
// tb_dc_bu_line_write_ctrl: directed table vectors plus hand sequences for overflow,
// mid-line sof, clock-enable stall and mid-line reset.
module tb_dc_bu_line_write_ctrl;
  logic        clk = 0, nrst = 0, en = 0, pix_valid = 0, pix_sof = 0, pix_eol = 0;
  logic [23:0] pix_data = '0;
  logic [8:0]  v_step = 9'd256;
  logic [4:0]  write_buff = 5'b00100;
  logic        pix_ready, next_line, no_func_switch, line_ovf;
  logic [4:0]  wr_en;
  logic [10:0] wr_addr;
  logic [23:0] wr_data;
  int          tests = 0, fails = 0, nwr = 0, nnl = 0;
  logic [4:0]  last_we;

  dc_bu_line_write_ctrl #(.BUFFER_NUM(5), .PIX_W(24), .ADDR_W(11), .LINE_W(8), .FRAC_W(8)) dut (
    .clk(clk), .nrst(nrst), .en(en), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .v_step(v_step),
    .write_buff(write_buff), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .next_line(next_line), .no_func_switch(no_func_switch), .line_ovf(line_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        e, v, s, l;
    logic [23:0] d;
    logic [8:0]  vs;
    logic        rdy;
    logic [4:0]  we;
    logic [10:0] wa;
    logic [23:0] wd;
    logic        nl, nfs;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int e, v, s, l, d, vs, rdy, we, wa, wd, nl, nfs);
    tbl.push_back('{e[0], v[0], s[0], l[0], d[23:0], vs[8:0], rdy[0], we[4:0], wa[10:0], wd[23:0], nl[0], nfs[0]});
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // one cycle: drive just after the rising edge, sample mid-cycle
  task automatic px(input logic e, v, s, l, input logic [23:0] d);
    @(posedge clk);
    #1;
    en = e; pix_valid = v; pix_sof = s; pix_eol = l; pix_data = d;
    #4;
    if (wr_en != 0) begin nwr++; last_we = wr_en; end
    if (next_line) nnl++;
  endtask

  initial begin
    //  en v s l data      vs   rdy we wa wd        nl nfs
    add(1, 0, 0, 0, 0,       256, 1, 0, 0, 0,       0, 0);
    add(1, 1, 1, 0, 'hA0,    256, 1, 0, 0, 0,       0, 0);
    add(1, 1, 0, 0, 'hA1,    256, 1, 4, 0, 'hA0,    0, 0);
    add(1, 1, 0, 0, 'hA2,    256, 1, 4, 1, 'hA1,    0, 0);
    add(1, 1, 0, 1, 'hA3,    256, 1, 4, 2, 'hA2,    0, 0);
    add(1, 1, 0, 0, 'hEE,    256, 0, 4, 3, 'hA3,    1, 0);
    add(1, 0, 0, 0, 0,       256, 1, 0, 3, 'hA3,    0, 0);
    add(1, 1, 1, 1, 'hB0,    128, 1, 0, 3, 'hA3,    0, 0);
    add(1, 0, 0, 0, 0,       128, 0, 4, 0, 'hB0,    1, 1);
    add(1, 1, 0, 1, 'hB1,    128, 1, 0, 0, 'hB0,    0, 0);
    add(1, 0, 0, 0, 0,       128, 0, 4, 0, 'hB1,    1, 0);
    add(1, 1, 0, 1, 'hB2,    128, 1, 0, 0, 'hB1,    0, 0);
    add(1, 0, 0, 0, 0,       128, 0, 4, 0, 'hB2,    1, 1);
    add(1, 1, 0, 1, 'hB3,    128, 1, 0, 0, 'hB2,    0, 0);
    add(1, 0, 0, 0, 0,       128, 0, 4, 0, 'hB3,    1, 0);
    add(1, 0, 0, 0, 0,       0,   1, 0, 0, 'hB3,    0, 0);
    add(1, 1, 1, 1, 'hC0,    0,   1, 0, 0, 'hB3,    0, 0);
    add(1, 0, 0, 0, 0,       0,   0, 4, 0, 'hC0,    1, 1);
    add(1, 1, 1, 1, 'hC1,    300, 1, 0, 0, 'hC0,    0, 0);
    add(1, 0, 0, 0, 0,       300, 0, 4, 0, 'hC1,    1, 0);
    add(1, 0, 0, 0, 0,       300, 1, 0, 0, 'hC1,    0, 0);

    en = 1; pix_valid = 1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst ready", pix_ready, 0);
    chk("rst wr_en", wr_en, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst next_line", next_line, 0);
    chk("rst nfs", no_func_switch, 0);
    chk("rst ovf", line_ovf, 0);
    pix_valid = 0;
    nrst = 1;

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      en = tbl[i].e; pix_valid = tbl[i].v; pix_sof = tbl[i].s; pix_eol = tbl[i].l;
      pix_data = tbl[i].d; v_step = tbl[i].vs;
      #4;
      chk($sformatf("vec%0d ready", i), pix_ready, tbl[i].rdy);
      chk($sformatf("vec%0d wr_en", i), wr_en, tbl[i].we);
      chk($sformatf("vec%0d wr_addr", i), wr_addr, tbl[i].wa);
      chk($sformatf("vec%0d wr_data", i), wr_data, tbl[i].wd);
      chk($sformatf("vec%0d next_line", i), next_line, tbl[i].nl);
      chk($sformatf("vec%0d nfs", i), no_func_switch, tbl[i].nfs);
      chk($sformatf("vec%0d ovf", i), line_ovf, 0);
    end

    // 10-pixel line into an 8-pixel buffer
    write_buff = 5'b01000; v_step = 9'd256; nwr = 0; nnl = 0;
    for (int i = 0; i < 10; i++) px(1, 1, i == 0, i == 9, 24'(100 + i));
    repeat (3) px(1, 0, 0, 0, 0);
    chk("ovf writes", nwr, 8);
    chk("ovf next_line count", nnl, 1);
    chk("ovf flag", line_ovf, 1);
    chk("ovf last addr", wr_addr, 7);
    chk("ovf last data", wr_data, 107);
    chk("ovf strobe", last_we, 5'b01000);
    px(1, 1, 1, 0, 200);
    chk("ovf held until sof", line_ovf, 1);
    px(1, 0, 0, 0, 0);
    chk("ovf cleared by sof", line_ovf, 0);
    chk("sof addr", wr_addr, 0);
    chk("sof data", wr_data, 200);

    // mid-line sof after acc was left at 128
    v_step = 9'd128;
    px(1, 1, 1, 1, 300);
    px(1, 0, 0, 0, 0);
    chk("pre line next_line", next_line, 1);
    nnl = 0;
    px(1, 1, 0, 0, 301);
    px(1, 1, 0, 0, 302);
    px(1, 1, 0, 0, 303);
    px(1, 1, 1, 0, 310);
    chk("midsof no next_line", nnl, 0);
    px(1, 1, 0, 1, 311);
    chk("midsof addr", wr_addr, 0);
    chk("midsof data", wr_data, 310);
    chk("midsof strobe", wr_en, 5'b01000);
    px(1, 0, 0, 0, 0);
    chk("midsof eol addr", wr_addr, 1);
    chk("midsof next_line", next_line, 1);
    chk("midsof acc restart", no_func_switch, 1);
    px(1, 0, 0, 0, 0);

    // clock-enable stall mid-line
    v_step = 9'd256;
    px(1, 1, 1, 0, 400);
    px(1, 1, 0, 0, 401);
    px(1, 0, 0, 0, 0);
    chk("en pre addr", wr_addr, 1);
    for (int i = 0; i < 5; i++) begin
      px(0, 1, 0, 0, 24'h4FF);
      chk($sformatf("en%0d ready", i), pix_ready, 0);
      chk($sformatf("en%0d wr_en", i), wr_en, 0);
      chk($sformatf("en%0d next_line", i), next_line, 0);
    end
    px(1, 1, 0, 0, 402);
    chk("en resume ready", pix_ready, 1);
    chk("en resume no write", wr_en, 0);
    px(1, 0, 0, 0, 0);
    chk("en resume addr", wr_addr, 2);
    chk("en resume data", wr_data, 402);
    chk("en resume strobe", wr_en, 5'b01000);

    // asynchronous reset mid-line, while a write is being shown
    px(1, 1, 0, 0, 500);
    @(posedge clk);
    #1;
    pix_valid = 0;
    #1;
    chk("prereset strobe", wr_en, 5'b01000);
    nrst = 0;
    #1;
    chk("reset ready", pix_ready, 0);
    chk("reset wr_en", wr_en, 0);
    chk("reset wr_addr", wr_addr, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset next_line", next_line, 0);
    chk("reset nfs", no_func_switch, 0);
    chk("reset ovf", line_ovf, 0);
    @(negedge clk);
    nrst = 1;
    nwr = 0; nnl = 0;
    px(1, 1, 0, 0, 501);
    chk("idle ready", pix_ready, 1);
    px(1, 1, 0, 1, 502);
    px(1, 1, 0, 0, 503);
    px(1, 0, 0, 0, 0);
    chk("idle drop writes", nwr, 0);
    chk("idle no next_line", nnl, 0);
    px(1, 1, 1, 0, 504);
    px(1, 0, 0, 0, 0);
    chk("post reset addr", wr_addr, 0);
    chk("post reset data", wr_data, 504);
    chk("post reset strobe", wr_en, 5'b01000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
